// File: rtl/spi_master.sv
// Mode-0 SPI master: multi-byte transactions with start/busy/done, per-byte tx_load and rx_valid.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions (default is MSB first).
module spi_master #(
    parameter int DIV    = 4,
    parameter int SS_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] len,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       ss,
    output logic       mosi,
    input  logic       miso
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = $clog2(SS_GAP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t        state, next_state;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic [7:0]    tx_sh, rx_sh, rx_data_q;
    logic          rx_valid_q, tx_load_q, sck_q, fin;
    logic          div_end, gap_end, start_ok, active, tx_bit, next_tx_bit;

    assign div_end  = (div_cnt == DW'(DIV - 1));
    assign gap_end  = (gap_cnt == GW'(SS_GAP - 1));
    assign start_ok = (state == IDLE) && start;
    assign active   = (state == SETUP) || (state == XFER) || (state == HOLD);

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_bit      = tx_sh[0];
    assign next_tx_bit = tx_data[0];
`else
    assign tx_bit      = tx_sh[7];
    assign next_tx_bit = tx_data[7];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // fin marks that the final byte's 8th fall has happened; XFER then runs one more low half-period.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SETUP;
            SETUP:   if (div_end) next_state = XFER;
            XFER:    if (div_end && !sck_q && fin) next_state = HOLD;
            HOLD:    if (div_end) next_state = GAP;
            GAP:     if (gap_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ss       = !active;
        sck      = sck_q;
        busy     = (state != IDLE);
        done     = (state == GAP) && gap_end;
        tx_load  = (start_ok && !rst) || tx_load_q;
        mosi     = active ? (tx_load_q ? next_tx_bit : tx_bit) : 1'b0;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            sck_q      <= 1'b0;
            fin        <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            div_cnt    <= (active && !div_end) ? div_cnt + 1'b1 : '0;
            gap_cnt    <= (state == GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
            if (start_ok) begin
                tx_sh    <= tx_data;
                byte_cnt <= len;
                bit_cnt  <= '0;
                fin      <= 1'b0;
                sck_q    <= 1'b0;
            end
            if (tx_load_q) tx_sh <= tx_data;
            if ((state == SETUP || state == XFER) && div_end) begin
                if (!sck_q) begin
                    if (!(state == XFER && fin)) begin
                        sck_q <= 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        rx_sh <= {miso, rx_sh[7:1]};
`else
                        rx_sh <= {rx_sh[6:0], miso};
`endif
                    end
                end else begin
                    sck_q <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        // Keep tx_sh on the last fall so mosi holds bit 0/7 through HOLD.
                        rx_data_q  <= rx_sh;
                        rx_valid_q <= 1'b1;
                        bit_cnt    <= '0;
                        if (byte_cnt == 4'd0) begin
                            fin <= 1'b1;
                        end else begin
                            byte_cnt  <= byte_cnt - 1'b1;
                            tx_load_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        tx_sh <= {1'b0, tx_sh[7:1]};
`else
                        tx_sh <= {tx_sh[6:0], 1'b0};
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DIV=4, SS_GAP=2) with miso looped back to mosi.
module tb_spi_master;
    localparam int DIV    = 4;
    localparam int SS_GAP = 2;

    logic       clk, rst, start, tx_load, rx_valid, busy, done, sck, ss, mosi, miso;
    logic [3:0] len;
    logic [7:0] tx_data, rx_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mosi_q[$];

    assign miso = mosi;

    spi_master #(.DIV(DIV), .SS_GAP(SS_GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .tx_data(tx_data),
        .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    // One transaction: n bytes d0..d2, optional reset at abort_at, optional stray start at poke_at.
    task automatic xfer(input string name, input int n, input logic [7:0] d0, d1, d2,
                        input int abort_at, input int poke_at, input int exp_done);
        logic [7:0] d[3];
        logic [7:0] bits;
        int cyc, rises, nbits, rx_cnt, load_cnt, done_cnt, done_cyc, busy_low, limit;
        logic prev_sck;
        d[0] = d0; d[1] = d1; d[2] = d2;
        exp_q.delete(); mosi_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            mosi_q.push_back(wire_order(d[i]));
        end
        rises = 0; nbits = 0; rx_cnt = 0; load_cnt = 0; done_cnt = 0;
        done_cyc = -1; busy_low = -1; prev_sck = 1'b0; bits = '0;
        limit = (abort_at >= 0) ? abort_at + 120 : exp_done + 60;
        @(posedge clk); #1;
        start = 1'b1; len = 4'(n - 1); tx_data = d[0]; cyc = 0;
        while (cyc < limit && !(done_cyc >= 0 && cyc > done_cyc + 1)) begin
            @(negedge clk);
            if (tx_load) begin
                chk({name, "_load_cyc"}, cyc, (load_cnt == 0) ? 0 : load_cnt * 16 * DIV + 1);
                load_cnt++;
            end
            if (sck && !prev_sck) begin
                rises++;
                bits = {bits[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (mosi_q.size() > 0) chk({name, "_mosi_seq"}, bits, mosi_q.pop_front());
                    else chk({name, "_extra_mosi_byte"}, 1, 0);
                end
            end
            prev_sck = sck;
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() > 0) chk({name, "_rx_data"}, rx_data, exp_q.pop_front());
                else chk({name, "_extra_rx_valid"}, 1, 0);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && busy_low < 0 && !busy) busy_low = cyc;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk({name, "_ss_after_rst"}, ss, 1);
                chk({name, "_sck_after_rst"}, sck, 0);
            end
            @(posedge clk); #1;
            cyc++;
            start = (cyc == poke_at);
            if (cyc == poke_at) len = 4'd15;
            rst = (cyc == abort_at);
            tx_data = d[(load_cnt < n) ? load_cnt : n - 1];
        end
        start = 1'b0; rst = 1'b0;
        if (abort_at >= 0) begin
            chk({name, "_rx_count"}, rx_cnt, 0);
            chk({name, "_done_count"}, done_cnt, 0);
            chk({name, "_busy_idle"}, busy, 0);
        end else begin
            chk({name, "_done_cyc"}, done_cyc, exp_done);
            chk({name, "_busy_low_cyc"}, busy_low, exp_done + 1);
            chk({name, "_done_count"}, done_cnt, 1);
            chk({name, "_rx_count"}, rx_cnt, n);
            chk({name, "_load_count"}, load_cnt, n);
            chk({name, "_sck_rises"}, rises, 8 * n);
            chk({name, "_exp_q_empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; tx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss", ss, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer("single", 1, 8'hA5, 8'h00, 8'h00, -1, -1, 74);
        chk("single_mosi_hold_idle", mosi, 0);
        xfer("burst", 3, 8'h3C, 8'h81, 8'hFF, -1, -1, 202);
        xfer("poke", 1, 8'h5A, 8'h00, 8'h00, -1, 40, 74);
        xfer("abort", 1, 8'hC3, 8'h00, 8'h00, 30, -1, 0);
        repeat (3) @(negedge clk);
        xfer("one", 1, 8'h01, 8'h00, 8'h00, -1, -1, 74);
        xfer("after_abort", 2, 8'h96, 8'h0F, 8'h00, -1, -1, 138);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master that sequences multi-byte transactions on the four-wire link (sck, ss, mosi, miso).
- Mode 0: CPOL=0, CPHA=0. MSB first by default.
- Generates sck from the system clock using a programmable half-period.
- The host side uses a start/busy/done handshake, a per-byte tx_load strobe and a per-byte rx_valid strobe.
- Sits between a host/sequencer and any downstream SPI slave in the design.

Parameters:
- DIV, 4, sck half-period in clk cycles (legal range ≥2).
- SS_GAP, 2, clk cycles ss stays high after a transaction before done and return to IDLE (legal range ≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a transaction; sampled only in IDLE
- len  in  4  byte count minus 1 (1..16 bytes); captured when start is accepted
- tx_data  in  8  byte to send; sampled on every clk where tx_load=1
- tx_load  out  1  one-cycle strobe: tx_data captured this cycle; host presents the next byte afterwards
- rx_data  out  8  last received byte; held until the next rx_valid
- rx_valid  out  1  one-cycle strobe: rx_data updated
- busy  out  1  transaction in progress
- done  out  1  one-cycle strobe: transaction complete
- sck  out  1  SPI clock; idle low
- ss  out  1  slave select; active low, idle high
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset (synchronous, highest priority, also mid-transaction):
  - ss=1, sck=0, mosi=0, busy=0, done=0, tx_load=0, rx_valid=0, rx_data=0.
  - State goes to IDLE; byte counter, bit counter and divider counter clear.
  - Mid-transaction reset aborts immediately. No done and no rx_valid for the partial byte.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - start=1 accepts the transaction (call this cycle 0).
  - tx_load=1 in cycle 0; tx_data and len are captured.
  - Next state is SETUP.
  - start is ignored in every non-IDLE state.
- SETUP:
  - Lasts DIV cycles (cycles 1..DIV).
  - ss=0, sck=0, mosi=bit7 of byte 0. busy=1.
- XFER:
  - sck toggles every DIV cycles; first rising edge is visible at cycle DIV+1.
  - On each sck rise: shift miso into the rx shift register.
  - On each sck fall: drive the next tx bit on mosi.
  - After the 8th fall of a byte:
    - rx_data is loaded and rx_valid=1 in the cycle sck goes low.
    - If bytes remain: tx_load=1 that same cycle, tx_data is captured and mosi = its bit7.
    - If no bytes remain: go to HOLD.
  - Each byte takes 16*DIV cycles.
- HOLD:
  - Lasts DIV cycles with sck=0 and ss=0.
  - mosi holds its last bit.
- GAP:
  - Lasts SS_GAP cycles with ss=1 and mosi=0.
  - done=1 and busy=1 on the last GAP cycle; next cycle is IDLE with busy=0.
- Timing: for N=len+1 bytes, done occurs at cycle T = (2+16N)*DIV + SS_GAP after cycle 0.
- Back-to-back: start held high while done=1 is accepted on the first IDLE cycle after done.
- Counters:
  - Divider counter is ceil(log2(DIV)) bits and wraps at DIV-1.
  - Bit counter is 3 bits.
  - Byte counter is 4 bits; it counts down from len and ends at 0.
- miso is sampled directly. The downstream slave is synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- Defined:
  - Both directions are LSB first.
  - mosi starts with bit0.
  - Received bits shift in at the MSB and move right, so the first received bit ends up at rx_data[0].
- Undefined: MSB first on both directions, as described above.
- Timing, handshake and port list are identical in both builds.

Test Plan:
- Reset values: assert rst for 3 cycles → every output equals its reset value; ss=1, sck=0.
- Single byte (DIV=4, SS_GAP=2, len=0, tx_data=0xA5, miso tied to mosi):
  - mosi bit sequence is 1,0,1,0,0,1,0,1.
  - Exactly 8 sck rises.
  - rx_valid once with rx_data=0xA5.
  - done at cycle 74; busy low at cycle 75.
- Burst (len=2; host supplies 0x3C, 0x81, 0xFF on successive tx_load; miso looped):
  - tx_load at cycle 0 and at the 8th and 16th sck falls.
  - rx_valid ×3 with 0x3C, 0x81, 0xFF.
  - done at cycle 202.
- Start during busy: pulse start mid-XFER → ignored; len and byte count unchanged; one done only.
- Reset mid-transaction: rst at cycle 30 of a single-byte transfer → ss=1 and sck=0 next cycle; no rx_valid; no done.
- LSB-first build (macro defined, tx_data=0x01, miso looped):
  - mosi first bit is 1, followed by seven 0s.
  - rx_data=0x01.
